// File: rtl/kypd_key_emulator.sv
// rtl/kypd_key_emulator.sv - keypad-side responder for a 4x4 PmodKYPD column-scan interface
//
// Purpose
//   Passive keypad model. Accepts "press key K for N cycles" commands and pulls the
//   key's row line low whenever the scanner drives that key's column low, while the
//   modelled contact is closed. Contact bounce is modelled on press and release,
//   followed by an open-contact guard gap.
//
// Ports
//   clk         in   1       system clock
//   rst_n       in   1       asynchronous active-low reset
//   cmd_valid   in   1       press command valid
//   cmd_ready   out  1       high only while idle; command taken on cmd_valid & cmd_ready
//   cmd_key     in   4       key code 0x0-0xF (decoder encoding)
//   cmd_hold    in   HOLD_W  steady-closed duration in cycles, 0 behaves as 1
//   col_n       in   4       scanner column lines, active-low, asynchronous to clk
//   row_n       out  4       row lines back to the scanner, active-low, registered
//   key_active  out  1       high during BOUNCE_IN, HOLD and BOUNCE_OUT
//   press_done  out  1       one-cycle pulse on the last GAP cycle

module kypd_key_emulator #(
  parameter int HOLD_W        = 24,
  parameter int BOUNCE_CYCLES = 1000,
  parameter int BOUNCE_PERIOD = 100,
  parameter int GAP_CYCLES    = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic [3:0]        col_n,
  output logic [3:0]        row_n,
  output logic              key_active,
  output logic              press_done
);

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared cycle counter serves every timed state, so it must cover the
  // longest of the bounce window, the gap and the largest hold value.
  localparam int BNC_W = max_int($clog2(BOUNCE_CYCLES + 1), 1);
  localparam int GAP_W = max_int($clog2(GAP_CYCLES + 1), 1);
  localparam int CNT_W = max_int(max_int(BNC_W, GAP_W), HOLD_W);
  localparam int PH_W  = max_int($clog2(BOUNCE_PERIOD + 1), 1);

  localparam logic [CNT_W-1:0] BOUNCE_LAST =
    (BOUNCE_CYCLES > 0) ? CNT_W'(BOUNCE_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] GAP_LAST =
    (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [PH_W-1:0] PH_LAST =
    (BOUNCE_PERIOD > 0) ? PH_W'(BOUNCE_PERIOD - 1) : '0;
  localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_IN,
    S_HOLD,
    S_BOUNCE_OUT,
    S_GAP
  } state_t;

  // Key code -> {row[1:0], col[1:0]} in the PmodKYPD layout:
  //   row3: 1 2 3 A, row2: 4 5 6 B, row1: 7 8 9 C, row0: 0 F E D
  //   listed from col3 down to col0.
  function automatic logic [3:0] key_pos(input logic [3:0] key);
    logic [3:0] pos;
    case (key)
      4'h0:    pos = {2'd0, 2'd3};
      4'h1:    pos = {2'd3, 2'd3};
      4'h2:    pos = {2'd3, 2'd2};
      4'h3:    pos = {2'd3, 2'd1};
      4'h4:    pos = {2'd2, 2'd3};
      4'h5:    pos = {2'd2, 2'd2};
      4'h6:    pos = {2'd2, 2'd1};
      4'h7:    pos = {2'd1, 2'd3};
      4'h8:    pos = {2'd1, 2'd2};
      4'h9:    pos = {2'd1, 2'd1};
      4'hA:    pos = {2'd3, 2'd0};
      4'hB:    pos = {2'd2, 2'd0};
      4'hC:    pos = {2'd1, 2'd0};
      4'hD:    pos = {2'd0, 2'd0};
      4'hE:    pos = {2'd0, 2'd1};
      default: pos = {2'd0, 2'd2};
    endcase
    return pos;
  endfunction

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [PH_W-1:0]   ph_cnt, ph_cnt_d;
  logic              bounce_closed, bounce_closed_d;
  logic [3:0]        key_q;
  logic [HOLD_W-1:0] hold_q;
  logic              latch_cmd;
  logic              contact;
  logic [CNT_W-1:0]  hold_last;

  logic [3:0]        col_meta, col_s;
  logic [3:0]        row_d;
  logic [3:0]        pos;
  logic [1:0]        key_row, key_col;

  // hold_q is never zero, so this subtraction cannot underflow.
  assign hold_last = CNT_W'(hold_q) - CNT_W'(1);

  // Contact bounce: a free phase counter inside the window flips the contact
  // every BOUNCE_PERIOD cycles. The initial level is set on window entry.
  always_comb begin
    state_d         = state;
    cnt_d           = cnt + CNT_W'(1);
    ph_cnt_d        = ph_cnt;
    bounce_closed_d = bounce_closed;
    latch_cmd       = 1'b0;
    cmd_ready       = 1'b0;
    key_active      = 1'b0;
    press_done      = 1'b0;
    contact         = 1'b0;

    if (state == S_BOUNCE_IN || state == S_BOUNCE_OUT) begin
      if (ph_cnt == PH_LAST) begin
        ph_cnt_d        = '0;
        bounce_closed_d = ~bounce_closed;
      end else begin
        ph_cnt_d = ph_cnt + PH_W'(1);
      end
    end

    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        cnt_d     = '0;
        if (cmd_valid) begin
          latch_cmd       = 1'b1;
          ph_cnt_d        = '0;
          bounce_closed_d = 1'b1;
          state_d         = HAS_BOUNCE ? S_BOUNCE_IN : S_HOLD;
        end
      end

      S_BOUNCE_IN: begin
        key_active = 1'b1;
        contact    = bounce_closed;
        if (cnt == BOUNCE_LAST) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        key_active = 1'b1;
        contact    = 1'b1;
        if (cnt == hold_last) begin
          cnt_d           = '0;
          ph_cnt_d        = '0;
          bounce_closed_d = 1'b0;
          state_d         = HAS_BOUNCE ? S_BOUNCE_OUT : S_GAP;
        end
      end

      S_BOUNCE_OUT: begin
        key_active = 1'b1;
        contact    = bounce_closed;
        if (cnt == BOUNCE_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (cnt == GAP_LAST) begin
          press_done = 1'b1;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      ph_cnt        <= '0;
      bounce_closed <= 1'b0;
      key_q         <= 4'h0;
      hold_q        <= HOLD_W'(1);
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      ph_cnt        <= ph_cnt_d;
      bounce_closed <= bounce_closed_d;
      if (latch_cmd) begin
        key_q  <= cmd_key;
        hold_q <= (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
      end
    end
  end

  // Row drive: only the latched key's row, only while the contact is closed and
  // the key's own column is low; other low columns are irrelevant.
  assign pos     = key_pos(key_q);
  assign key_row = pos[3:2];
  assign key_col = pos[1:0];

  always_comb begin
    row_d = 4'hF;
    if (contact && !col_s[key_col]) begin
      row_d[key_row] = 1'b0;
    end
  end

  // col_n is asynchronous: two flops before use, then the registered row_n,
  // giving a fixed three-cycle column-to-row latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'hF;
      col_s    <= 4'hF;
      row_n    <= 4'hF;
    end else begin
      col_meta <= col_n;
      col_s    <= col_meta;
      row_n    <= row_d;
    end
  end

endmodule

// File: tb/tb_kypd_key_emulator.sv
// tb/tb_kypd_key_emulator.sv - scoreboard bench for kypd_key_emulator

module tb_kypd_key_emulator;

  localparam int HW = 8;
  localparam int BC = 20;
  localparam int BP = 5;
  localparam int GC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_key;
  logic [HW-1:0] cmd_hold;
  logic [3:0]    col_n;
  logic [3:0]    row_n;
  logic          key_active;
  logic          press_done;

  always #5 clk = ~clk;

  kypd_key_emulator #(
    .HOLD_W(HW), .BOUNCE_CYCLES(BC), .BOUNCE_PERIOD(BP), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_key(cmd_key), .cmd_hold(cmd_hold), .col_n(col_n), .row_n(row_n),
    .key_active(key_active), .press_done(press_done)
  );

  typedef struct {
    int key;
    int done_at;
    int act;
    int low;
    int runs;
    int first;
    int last;
    bit chk_dec;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Key layout row by row (row3 at top), each row listed col3..col0.
  logic [63:0] keymap = 64'h123A_456B_789C_0FED;
  int row_of[16];
  int col_of[16];

  function automatic int map_at(input int r, input int c);
    return int'(keymap[r*16 + c*4 +: 4]);
  endfunction

  function automatic void check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // mode 1: column steady and matching, 0: column never matches, 2: scanning.
  // With BC=20, BP=5, GC=4 and H = max(hold,1), counting cycles from 1 after accept:
  //   contact closed 1-5, 11-15, 21..20+H, H+26..H+30, H+36..H+40 (5 runs, H+20 cycles)
  //   row_n follows one cycle later: first low at 2, last low at H+41
  //   key_active for H+40 cycles, press_done at H+44.
  function automatic exp_t mk(input int key, input int hold, input int mode, input bit dec);
    exp_t e;
    int h;
    h = (hold < 1) ? 1 : hold;
    e.key = key;
    e.done_at = h + 44;
    e.act = h + 40;
    e.chk_dec = dec;
    if (mode == 1) begin
      e.low = h + 20; e.runs = 5; e.first = 2; e.last = h + 41;
    end else if (mode == 0) begin
      e.low = 0; e.runs = 0; e.first = 0; e.last = 0;
    end else begin
      e.low = -1; e.runs = -1; e.first = -1; e.last = -1;
    end
    return e;
  endfunction

  // Column driver: static value, or a decoder-like rotation every 8 cycles.
  logic [3:0] col_static = 4'hF;
  bit scan_en = 1'b0;
  initial begin
    int tick;
    tick = 0;
    col_n = 4'hF;
    forever begin
      @(posedge clk);
      #1;
      if (scan_en) begin
        if (tick == 7) begin
          tick = 0;
          col_n = {col_n[0], col_n[3:1]};
        end else begin
          tick++;
        end
      end else begin
        col_n = col_static;
        tick = 0;
      end
    end
  end

  // Monitor: measures each press between accept and press_done, then pops the
  // expected record and compares.
  initial begin
    logic [3:0] hist[4];
    logic [3:0] exp_row;
    int in_press, cyc, act, low, runs, first, last, bad, prev_low, dec, got_dec, chk_rdy;
    int k, cc, rr;
    exp_t e;
    for (int i = 0; i < 4; i++) hist[i] = 4'hF;
    in_press = 0; chk_rdy = 0;
    cyc = 0; act = 0; low = 0; runs = 0; first = 0; last = 0; bad = 0;
    prev_low = 0; dec = -1; got_dec = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_press = 0;
        chk_rdy = 0;
        sb.delete();
      end else begin
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = col_n;
        if (chk_rdy != 0) begin
          check("ready_after_done", int'(cmd_ready), 1);
          chk_rdy = 0;
        end
        if (in_press != 0 && sb.size() > 0) begin
          cyc++;
          if (key_active) act++;
          if (row_n != 4'hF) begin
            low++;
            if (prev_low == 0) runs++;
            if (first == 0) first = cyc;
            last = cyc;
            prev_low = 1;
            k = sb[0].key;
            exp_row = ~(4'b0001 << row_of[k]);
            if (!(row_n == exp_row && hist[3][col_of[k]] == 1'b0)) bad++;
            if (got_dec == 0 && $countones(~hist[3]) == 1 && $countones(~row_n) == 1) begin
              cc = 0; rr = 0;
              for (int i = 0; i < 4; i++) begin
                if (!hist[3][i]) cc = i;
                if (!row_n[i]) rr = i;
              end
              dec = map_at(rr, cc);
              got_dec = 1;
            end
          end else begin
            prev_low = 0;
          end
        end else if (row_n != 4'hF) begin
          check("row_idle", int'(row_n), 15);
        end
        if (press_done) begin
          if (in_press == 0 || sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check($sformatf("done_at_k%0h", e.key), cyc, e.done_at);
            check($sformatf("active_k%0h", e.key), act, e.act);
            if (e.low >= 0) check($sformatf("low_cnt_k%0h", e.key), low, e.low);
            else check($sformatf("low_any_k%0h", e.key), int'(low > 0), 1);
            if (e.runs >= 0) check($sformatf("runs_k%0h", e.key), runs, e.runs);
            if (e.first >= 0) begin
              check($sformatf("first_low_k%0h", e.key), first, e.first);
              check($sformatf("last_low_k%0h", e.key), last, e.last);
            end
            check($sformatf("row_col_k%0h", e.key), bad, 0);
            if (e.chk_dec) check($sformatf("decode_k%0h", e.key), dec, e.key);
          end
          in_press = 0;
          chk_rdy = 1;
        end
        if (cmd_valid && cmd_ready) begin
          in_press = 1;
          cyc = 0; act = 0; low = 0; runs = 0; first = 0; last = 0; bad = 0;
          prev_low = 0; dec = -1; got_dec = 0;
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(cmd_ready && sb.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!(cmd_ready && sb.size() == 0)) check("idle_timeout", 0, 1);
  endtask

  task automatic set_col(input logic [3:0] c);
    col_static = c;
    repeat (5) @(posedge clk);
  endtask

  task automatic issue(input int key, input int hold, input int mode, input bit dec);
    wait_ready();
    @(posedge clk);
    #1;
    sb.push_back(mk(key, hold, mode, dec));
    cmd_valid = 1'b1;
    cmd_key = 4'(key);
    cmd_hold = HW'(hold);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        row_of[map_at(r, c)] = r;
        col_of[map_at(r, c)] = c;
      end
    end
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_key = 4'h0;
    cmd_hold = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row_n", int'(row_n), 15);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_key_active", int'(key_active), 0);
    check("rst_press_done", int'(press_done), 0);
    rst_n = 1'b1;

    // Steady matching column, key 5 (col2,row2).
    set_col(4'b1011);
    issue(5, 10, 1, 1'b1);
    wait_idle();

    // Non-matching column: contact timing still runs, rows stay high.
    set_col(4'b1101);
    issue(5, 10, 0, 1'b0);
    wait_idle();

    // Key D (col0,row0) with the bounce pattern visible on row0.
    set_col(4'b1110);
    issue(4'hD, 30, 1, 1'b1);
    wait_idle();

    // Key 0 (col3,row0).
    set_col(4'b0111);
    issue(0, 7, 1, 1'b1);
    wait_idle();

    // cmd_valid held through busy: key 1 hold 0 first, then inputs switch to
    // key 6 hold 50 while busy; the second accept happens only after press_done.
    set_col(4'b0101);
    wait_ready();
    @(posedge clk);
    #1;
    sb.push_back(mk(1, 0, 1, 1'b0));
    sb.push_back(mk(6, 50, 1, 1'b0));
    cmd_valid = 1'b1;
    cmd_key = 4'h1;
    cmd_hold = '0;
    @(posedge clk);
    #1;
    cmd_key = 4'h6;
    cmd_hold = HW'(50);
    wait_ready();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle();

    // Decoder-like rotating scan over every key code.
    col_static = 4'b0111;
    repeat (3) @(posedge clk);
    scan_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      issue(k, 60, 2, 1'b1);
      wait_idle();
    end
    scan_en = 1'b0;
    col_static = 4'hF;

    // Reset in the middle of HOLD drops the press with no press_done.
    set_col(4'b1011);
    issue(5, 100, 1, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    check("hold_row_n", int'(row_n), 11);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_row_n", int'(row_n), 15);
    check("midrst_key_active", int'(key_active), 0);
    check("midrst_cmd_ready", int'(cmd_ready), 1);
    check("midrst_press_done", int'(press_done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (150) @(posedge clk);

    // Recovery press after reset: key F (col2,row0).
    issue(4'hF, 3, 1, 1'b1);
    wait_idle();
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
